// File: rtl/regfile_pkg.sv
// Shared widths, register-file constants and the writeback entry type.
package regfile_pkg;
    localparam int REG_W    = 5;
    localparam int DATA_W   = 32;
    localparam int NUM_REGS = 32;
    localparam logic [REG_W-1:0] ZERO_REG = '0;

    typedef struct packed {
        logic [REG_W-1:0]  reg_idx;
        logic [DATA_W-1:0] data;
    } wb_entry_t;
endpackage

// File: rtl/wb_fifo.sv
// In-order FIFO of writeback entries; pointers wrap modulo DEPTH.
// Latency: an entry pushed at edge N can be popped at edge N+1.
// Backpressure: push ignored when full, pop ignored when empty.
module wb_fifo import regfile_pkg::*; #(
    parameter int DEPTH = 2
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       push,
    input  wb_entry_t                  push_entry,
    input  logic                       pop,
    output wb_entry_t                  head,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH+1);

    wb_entry_t        mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH-1)) ? '0 : p + 1'b1;
    endfunction

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr] <= push_entry;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= bump(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= bump(rd_ptr);
            end
            if (do_push && !do_pop) begin
                count <= count + 1'b1;
            end else if (!do_push && do_pop) begin
                count <= count - 1'b1;
            end
        end
    end
endmodule

// File: rtl/regfile_writeback.sv
// Sole driver of the register-file write port: merges pipeline and multdiv results, drops r0.
// Latency: pipeline result written one edge after acceptance; multdiv result at least two.
// Backpressure: wb_ready/md_ready drop only while the multdiv FIFO is full.
module regfile_writeback #(
    parameter int DEPTH  = 2,
    parameter int REG_W  = regfile_pkg::REG_W,
    parameter int DATA_W = regfile_pkg::DATA_W
) (
    input  logic              clock,
    input  logic              ctrl_reset_n,
    input  logic              wb_valid,
    output logic              wb_ready,
    input  logic [REG_W-1:0]  wb_reg,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              md_valid,
    output logic              md_ready,
    input  logic [REG_W-1:0]  md_reg,
    input  logic [DATA_W-1:0] md_data,
    input  logic              md_issue,
    input  logic [REG_W-1:0]  md_issue_reg,
    output logic [31:0]       pending,
    output logic              ctrl_writeEnable,
    output logic [REG_W-1:0]  ctrl_writeReg,
    output logic [DATA_W-1:0] data_writeReg
);
    import regfile_pkg::*;

    localparam int CNT_W = $clog2(DEPTH+1);

    wb_entry_t          wb_in;
    wb_entry_t          md_in;
    wb_entry_t          head;
    wb_entry_t          win;
    logic [CNT_W-1:0]   fifo_count;
    logic               full;
    logic               empty;
    logic               pop;
    logic               push;
    logic               win_vld;
    logic               do_write;
    logic [NUM_REGS-1:0] pending_q;
    logic [NUM_REGS-1:0] pending_nxt;

    assign wb_in    = '{reg_idx: wb_reg, data: wb_data};
    assign md_in    = '{reg_idx: md_reg, data: md_data};
    assign md_ready = ~full;
    assign wb_ready = ~full;
    assign push     = md_valid & ~full;
    assign pending  = pending_q;

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clock      (clock),
        .reset_n    (ctrl_reset_n),
        .push       (push),
        .push_entry (md_in),
        .pop        (pop),
        .head       (head),
        .count      (fifo_count),
        .full       (full),
        .empty      (empty)
    );

    // A full FIFO preempts the pipeline so it always drains.
    always_comb begin
        pop     = 1'b0;
        win_vld = 1'b0;
        win     = wb_in;
        if (full) begin
            pop     = 1'b1;
            win_vld = 1'b1;
            win     = head;
        end else if (wb_valid) begin
            win_vld = 1'b1;
        end else if (!empty) begin
            pop     = 1'b1;
            win_vld = 1'b1;
            win     = head;
        end
    end

    assign do_write = win_vld && (win.reg_idx != ZERO_REG);

    // Clear before set so an issue landing on the popped register stays pending.
    always_comb begin
        pending_nxt = pending_q;
        if (pop) begin
            pending_nxt[head.reg_idx] = 1'b0;
        end
        if (md_issue && (md_issue_reg != ZERO_REG)) begin
            pending_nxt[md_issue_reg] = 1'b1;
        end
        pending_nxt[0] = 1'b0;
    end

    always_ff @(posedge clock) begin
        if (!ctrl_reset_n) begin
            ctrl_writeEnable <= 1'b0;
            ctrl_writeReg    <= '0;
            data_writeReg    <= '0;
            pending_q        <= '0;
        end else begin
            ctrl_writeEnable <= do_write;
            if (do_write) begin
                ctrl_writeReg <= win.reg_idx;
                data_writeReg <= win.data;
            end
            pending_q <= pending_nxt;
        end
    end

    logic unused_count;
    assign unused_count = ^fifo_count;
endmodule
